// File: rtl/elevator_call_panel.sv
// rtl/elevator_call_panel.sv - debounced call buttons, call lamps and round-robin ip request issue
module elevator_call_panel #(
    parameter int NUM_FLOORS = 8,
    parameter int DB_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [2:0]            curr_floor,
    input  logic                  door,
    output logic [2:0]            floor_no,
    output logic                  ip,
    output logic [NUM_FLOORS-1:0] call_lamp
);
    localparam int N = NUM_FLOORS;

    logic [N-1:0] s1, s2, db, db_prev;
    logic [7:0]   cnt [N];
    logic [N-1:0] pend, lamp_q;
    logic [2:0]   rr;

    logic [N-1:0] arr_mask, accept, eligible, issue_mask;
    logic         found;
    logic [2:0]   sel_idx;
    logic [2:0]   rr_next;

    // Arrival never matches floors >= N, so out-of-range curr_floor clears nothing.
    always_comb begin
        arr_mask = '0;
        for (int i = 0; i < N; i++) begin
            arr_mask[i] = door && (curr_floor == 3'(i));
        end
    end

    assign accept   = db & ~db_prev & ~lamp_q & ~arr_mask;
    assign eligible = pend & ~arr_mask;

    // Circular scan starting at rr picks the first eligible pending floor.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && eligible[(int'(rr) + k) % N]) begin
                found   = 1'b1;
                sel_idx = 3'((int'(rr) + k) % N);
            end
        end
        rr_next    = 3'((int'(sel_idx) + 1) % N);
        issue_mask = '0;
        for (int i = 0; i < N; i++) begin
            issue_mask[i] = found && (sel_idx == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            db       <= '0;
            db_prev  <= '0;
            pend     <= '0;
            lamp_q   <= '0;
            rr       <= '0;
            ip       <= 1'b0;
            floor_no <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1      <= btn;
            s2      <= s1;
            db_prev <= db;
            for (int i = 0; i < N; i++) begin
                if (s2[i] != db[i]) begin
                    if (cnt[i] == 8'(DB_CYCLES - 1)) begin
                        db[i]  <= s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
            // Arrival masking last lets it win over same-cycle accept or issue.
            pend   <= (pend | accept) & ~issue_mask & ~arr_mask;
            lamp_q <= (lamp_q | accept) & ~arr_mask;
            ip     <= found;
            if (found) begin
                floor_no <= sel_idx;
                rr       <= rr_next;
            end
        end
    end

    assign call_lamp = lamp_q;
endmodule

// File: tb/tb_elevator_call_panel.sv
// tb/tb_elevator_call_panel.sv - scoreboard bench for elevator_call_panel
module tb_elevator_call_panel;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] btn;
    logic [2:0] curr_floor;
    logic       door;
    logic [2:0] floor_no;
    logic       ip;
    logic [7:0] call_lamp;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q [$];

    elevator_call_panel #(.NUM_FLOORS(8), .DB_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .curr_floor (curr_floor),
        .door       (door),
        .floor_no   (floor_no),
        .ip         (ip),
        .call_lamp  (call_lamp)
    );

    always #5 clk = ~clk;

    // Every ip strobe must match the next expected floor in order.
    always @(negedge clk) begin
        if (ip) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ip actual floor_no=%0d required no request", floor_no);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (floor_no !== e) begin
                    errors++;
                    $display("FAIL ip_floor actual=%0d required=%0d", floor_no, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; btn = '0; curr_floor = 3'd0; door = 1'b0;
        tick(); tick();
        chk("reset_lamp", 32'(call_lamp), 32'h0);
        chk("reset_ip", 32'(ip), 32'h0);
        chk("reset_floor", 32'(floor_no), 32'h0);

        // held button: exact latency
        rst_n = 1'b1; btn[5] = 1'b1; exp_q.push_back(3'd5);
        repeat (6) tick();
        chk("t1_lamp_e6", 32'(call_lamp), 32'h00);
        tick();
        chk("t1_lamp_e7", 32'(call_lamp), 32'h20);
        chk("t1_ip_e7", 32'(ip), 32'h0);
        tick();
        chk("t1_ip_e8", 32'(ip), 32'h1);
        chk("t1_floor_e8", 32'(floor_no), 32'h5);
        tick();
        chk("t1_ip_e9", 32'(ip), 32'h0);
        btn = '0;
        repeat (10) tick();

        // short pulses never debounce
        for (int p = 0; p < 4; p++) begin
            btn[2] = 1'b1;
            repeat (3) tick();
            btn[2] = 1'b0;
            repeat (4) tick();
        end
        repeat (8) tick();
        chk("t2_lamp", 32'(call_lamp), 32'h20);

        // duplicate press, arrival clear, press while served
        btn[3] = 1'b1; exp_q.push_back(3'd3);
        repeat (9) tick();
        chk("t4_lamp_set", 32'(call_lamp), 32'h28);
        btn[3] = 1'b0;
        repeat (8) tick();
        btn[3] = 1'b1;
        repeat (10) tick();
        chk("t4_dup_lamp", 32'(call_lamp), 32'h28);
        btn[3] = 1'b0;
        repeat (8) tick();
        curr_floor = 3'd3; door = 1'b1;
        tick();
        chk("t4_arrival_clear", 32'(call_lamp), 32'h20);
        btn[3] = 1'b1;
        repeat (10) tick();
        chk("t4_served_press", 32'(call_lamp), 32'h20);
        btn[3] = 1'b0;
        repeat (8) tick();
        door = 1'b0; curr_floor = 3'd0;

        // issue floor 4 so rr becomes 5, then clear lamps 4 and 5
        btn[4] = 1'b1; exp_q.push_back(3'd4);
        repeat (9) tick();
        chk("rr_prep_lamp", 32'(call_lamp), 32'h30);
        btn[4] = 1'b0;
        repeat (8) tick();
        curr_floor = 3'd4; door = 1'b1;
        tick();
        curr_floor = 3'd5;
        tick();
        door = 1'b0; curr_floor = 3'd0;
        chk("rr_prep_clear", 32'(call_lamp), 32'h00);

        // simultaneous presses drain in rr order from 5
        btn = 8'h52;
        exp_q.push_back(3'd6); exp_q.push_back(3'd1); exp_q.push_back(3'd4);
        repeat (6) tick();
        chk("t3_lamp_e6", 32'(call_lamp), 32'h00);
        tick();
        chk("t3_lamp_e7", 32'(call_lamp), 32'h52);
        chk("t3_ip_e7", 32'(ip), 32'h0);
        tick();
        chk("t3_ip_a", 32'(ip), 32'h1);
        chk("t3_floor_a", 32'(floor_no), 32'h6);
        tick();
        chk("t3_ip_b", 32'(ip), 32'h1);
        chk("t3_floor_b", 32'(floor_no), 32'h1);
        tick();
        chk("t3_ip_c", 32'(ip), 32'h1);
        chk("t3_floor_c", 32'(floor_no), 32'h4);
        tick();
        chk("t3_ip_end", 32'(ip), 32'h0);
        chk("t3_lamps", 32'(call_lamp), 32'h52);
        btn = '0;
        repeat (8) tick();

        // arrival in the issue cycle suppresses the request
        btn[2] = 1'b1;
        repeat (7) tick();
        chk("t5_lamp_set", 32'(call_lamp), 32'h56);
        curr_floor = 3'd2; door = 1'b1;
        tick();
        chk("t5_lamp_clear", 32'(call_lamp), 32'h52);
        chk("t5_no_ip", 32'(ip), 32'h0);
        btn[2] = 1'b0;
        repeat (8) tick();
        door = 1'b0; curr_floor = 3'd0;
        repeat (4) tick();

        // reset with pending calls and a held button
        btn = 8'hA8;
        repeat (2) tick();
        btn[0] = 1'b1;
        repeat (5) tick();
        chk("t6_lamp_pre", 32'(call_lamp), 32'hFA);
        rst_n = 1'b0;
        tick();
        chk("t6_lamp_rst", 32'(call_lamp), 32'h00);
        chk("t6_ip_rst", 32'(ip), 32'h0);
        rst_n = 1'b1; btn = 8'h01; exp_q.push_back(3'd0);
        repeat (6) tick();
        chk("t6_lamp_e6", 32'(call_lamp), 32'h00);
        tick();
        chk("t6_lamp_e7", 32'(call_lamp), 32'h01);
        chk("t6_ip_e7", 32'(ip), 32'h0);
        tick();
        chk("t6_ip_e8", 32'(ip), 32'h1);
        chk("t6_floor_e8", 32'(floor_no), 32'h0);
        tick();
        chk("t6_ip_e9", 32'(ip), 32'h0);
        btn = '0;
        repeat (8) tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
